// File: rtl/mmio_io_ctrl_if.sv
// mmio_io_ctrl_if: MMIO bus, retire strobe and UART rx/tx ready-valid channels
interface mmio_io_ctrl_if #(parameter int ADDR_W = 8);
  logic [ADDR_W-1:0] addr;
  logic [31:0] wdata;
  logic [3:0] we;
  logic re;
  logic [31:0] rdata;
  logic inst_retire;
  logic [7:0] uart_rx_data;
  logic uart_rx_valid;
  logic uart_rx_ready;
  logic [7:0] uart_tx_data;
  logic uart_tx_valid;
  logic uart_tx_ready;
  modport slave (
    input addr, wdata, we, re, inst_retire, uart_rx_data, uart_rx_valid, uart_tx_ready,
    output rdata, uart_rx_ready, uart_tx_data, uart_tx_valid
  );
  modport master (
    output addr, wdata, we, re, inst_retire, uart_rx_data, uart_rx_valid, uart_tx_ready,
    input rdata, uart_rx_ready, uart_tx_data, uart_tx_valid
  );
endinterface

// File: rtl/mmio_io_ctrl.sv
// mmio_io_ctrl: MMIO register block with UART rx/tx FIFOs and cycle/instruction counters
module mmio_io_ctrl #(
  parameter int RX_DEPTH = 8,
  parameter int TX_DEPTH = 8,
  parameter int CNT_W = 32,
  parameter int ADDR_W = 8
) (
  input logic clk,
  input logic rst,
  mmio_io_ctrl_if.slave bus
);
  localparam int RA = $clog2(RX_DEPTH);
  localparam int TA = $clog2(TX_DEPTH);
  localparam int WW = ADDR_W - 2;
  logic [7:0] rx_mem [RX_DEPTH];
  logic [7:0] tx_mem [TX_DEPTH];
  logic [RA:0] rx_wp, rx_rp, rx_cnt;
  logic [TA:0] tx_wp, tx_rp, tx_cnt;
  logic [CNT_W-1:0] cycle_cnt, inst_cnt;
  logic ovf;
  logic [WW-1:0] wa;
  logic wr, s_stat, s_rx, s_tx, s_clr;
  logic rx_full, rx_empty, tx_full, tx_empty;
  logic rx_push, rx_pop, tx_try, tx_push, tx_pop;
  logic [31:0] rd;
  always_comb begin
    wa = bus.addr[ADDR_W-1:2];
    wr = |bus.we;
    s_stat = wa == WW'(0);
    s_rx = wa == WW'(1);
    s_tx = wa == WW'(2);
    s_clr = wa == WW'(6);
    rx_cnt = rx_wp - rx_rp;
    tx_cnt = tx_wp - tx_rp;
    rx_full = rx_cnt == (RA+1)'(RX_DEPTH);
    tx_full = tx_cnt == (TA+1)'(TX_DEPTH);
    rx_empty = rx_cnt == '0;
    tx_empty = tx_cnt == '0;
    rx_push = bus.uart_rx_valid && !rx_full;
    rx_pop = bus.re && s_rx && !rx_empty;
    tx_try = bus.we[0] && s_tx;
    tx_push = tx_try && !tx_full;
    tx_pop = !tx_empty && bus.uart_tx_ready;
  end
  assign bus.uart_rx_ready = !rx_full;
  assign bus.uart_tx_valid = !tx_empty;
  assign bus.uart_tx_data = tx_mem[tx_rp[TA-1:0]];
  always_comb begin
    rd = '0;
    case (wa)
      WW'(0): rd = {29'b0, ovf, !rx_empty, !tx_full};
      WW'(1): rd = {24'b0, rx_empty ? 8'h00 : rx_mem[rx_rp[RA-1:0]]};
      WW'(4): rd = cycle_cnt[31:0];
      WW'(5): rd = inst_cnt[31:0];
      WW'(7): rd = {16'(tx_cnt), 16'(rx_cnt)};
      default: rd = '0;
    endcase
  end
  // storage needs no reset; pointers alone define contents
  always_ff @(posedge clk) begin
    if (rx_push && !rst) rx_mem[rx_wp[RA-1:0]] <= bus.uart_rx_data;
    if (tx_push && !rst) tx_mem[tx_wp[TA-1:0]] <= bus.wdata[7:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wp <= '0;
      rx_rp <= '0;
      tx_wp <= '0;
      tx_rp <= '0;
      cycle_cnt <= '0;
      inst_cnt <= '0;
      ovf <= 1'b0;
      bus.rdata <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop) tx_rp <= tx_rp + 1'b1;
      cycle_cnt <= wr && s_clr ? '0 : cycle_cnt + CNT_W'(1);
      inst_cnt <= wr && s_clr ? '0 : inst_cnt + CNT_W'(bus.inst_retire);
      ovf <= wr && s_stat ? 1'b0 : (tx_try && tx_full) ? 1'b1 : ovf;
      if (bus.re) bus.rdata <= rd;
    end
  end
endmodule

// File: tb/tb_mmio_io_ctrl.sv
// tb_mmio_io_ctrl: directed stimulus with queued expectations checked by rdata and tx monitors
module tb_mmio_io_ctrl;
  typedef struct {
    logic [31:0] v;
    string n;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  int total = 0;
  int bad = 0;
  bit pend = 0;
  exp_t rq[$];
  logic [7:0] tq[$];
  mmio_io_ctrl_if #(.ADDR_W(8)) bus();
  mmio_io_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input logic [7:0] a, input logic [31:0] e, input string n);
    bus.addr = a;
    bus.re = 1;
    rq.push_back('{e, n});
    cyc();
    bus.re = 0;
  endtask
  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] w);
    bus.addr = a;
    bus.wdata = d;
    bus.we = w;
    cyc();
    bus.we = 0;
  endtask
  task automatic rx(input logic [7:0] b);
    bus.uart_rx_data = b;
    bus.uart_rx_valid = 1;
    cyc();
    bus.uart_rx_valid = 0;
  endtask
  always @(negedge clk) begin
    if (pend) begin
      if (rq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rdata_unexpected: got %h expected none", bus.rdata);
      end else begin
        exp_t x;
        x = rq.pop_front();
        chk(x.n, bus.rdata, x.v);
      end
    end
    pend = bus.re && !rst;
  end
  always @(negedge clk) begin
    if (!rst && bus.uart_tx_valid && bus.uart_tx_ready) begin
      if (tq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL tx_unexpected: got %h expected none", bus.uart_tx_data);
      end else chk("tx_byte", {24'b0, bus.uart_tx_data}, {24'b0, tq.pop_front()});
    end
  end
  initial begin
    bus.addr = 0;
    bus.wdata = 0;
    bus.we = 0;
    bus.re = 0;
    bus.inst_retire = 0;
    bus.uart_rx_data = 0;
    bus.uart_rx_valid = 0;
    bus.uart_tx_ready = 0;
    repeat (3) cyc();
    rst = 0;
    chk("rst_tx_valid", {31'b0, bus.uart_tx_valid}, 0);
    chk("rst_rx_ready", {31'b0, bus.uart_rx_ready}, 1);
    chk("rst_rdata", bus.rdata, 0);
    rd(8'h00, 32'h1, "rst_status");
    rd(8'h1C, 32'h0, "rst_occ");
    rx(8'h41);
    rx(8'h42);
    rd(8'h00, 32'h3, "rx_status_ne");
    rd(8'h04, 32'h41, "rx_pop1");
    rd(8'h04, 32'h42, "rx_pop2");
    rd(8'h00, 32'h1, "rx_status_e");
    for (int i = 0; i < 9; i++) begin
      wr(8'h08, 32'h60 + i, 4'h1);
      if (i < 8) tq.push_back(8'(8'h60 + i));
    end
    chk("tx_head", {24'b0, bus.uart_tx_data}, 32'h60);
    rd(8'h1C, 32'h0008_0000, "tx_occ_full");
    rd(8'h00, 32'h4, "tx_ovf_set");
    wr(8'h0C, 32'hFFFF_FFFF, 4'hF);
    rd(8'h0C, 32'h0, "unmapped_rd");
    rd(8'h08, 32'h0, "txdata_rd");
    rd(8'h1C, 32'h0008_0000, "occ_after_unmapped");
    wr(8'h00, 32'h0, 4'h2);
    rd(8'h00, 32'h0, "tx_ovf_clr");
    bus.uart_tx_ready = 1;
    repeat (8) cyc();
    chk("tx_drained_valid", {31'b0, bus.uart_tx_valid}, 0);
    chk("tx_all_seen", tq.size(), 0);
    wr(8'h18, 32'h0, 4'h1);
    for (int i = 0; i < 100; i++) begin
      bus.inst_retire = i < 40;
      cyc();
    end
    bus.inst_retire = 0;
    rd(8'h14, 32'd40, "inst_cnt");
    rd(8'h10, 32'd101, "cycle_cnt");
    wr(8'h18, 32'h0, 4'h8);
    rd(8'h10, 32'd0, "cycle_cleared");
    rd(8'h14, 32'd0, "inst_cleared");
    bus.addr = 8'h04;
    bus.re = 1;
    bus.uart_rx_data = 8'h55;
    bus.uart_rx_valid = 1;
    rq.push_back('{32'h0, "rx_empty_pop"});
    cyc();
    bus.re = 0;
    bus.uart_rx_valid = 0;
    rd(8'h04, 32'h55, "rx_no_bypass");
    rx(8'h01);
    rx(8'h02);
    rx(8'h03);
    bus.addr = 8'h04;
    bus.re = 1;
    bus.uart_rx_data = 8'h04;
    bus.uart_rx_valid = 1;
    rq.push_back('{32'h1, "rx_push_pop"});
    cyc();
    bus.re = 0;
    bus.uart_rx_valid = 0;
    rd(8'h1C, 32'h3, "rx_occ_3");
    rst = 1;
    bus.uart_rx_data = 8'h99;
    bus.uart_rx_valid = 1;
    bus.addr = 8'h08;
    bus.we = 4'h1;
    repeat (2) cyc();
    rst = 0;
    bus.uart_rx_valid = 0;
    bus.we = 0;
    chk("rst2_rdata", bus.rdata, 0);
    rd(8'h1C, 32'h0, "rst2_occ");
    rd(8'h00, 32'h1, "rst2_status");
    repeat (2) cyc();
    chk("reads_all_seen", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
